// File: rtl/module_detector.sv
`default_nettype none
//============================================================================
// Module      : module_detector
// Description : 4x4 active-low matrix keypad decoder with input
//               synchronisation and a debouncing state machine. A key code is
//               accepted once the same key has been seen for DEBOUNCE_CYCLES
//               consecutive synchronised samples. The accepted code is held on
//               key_pressed until the next acceptance or reset.
//
// Parameters  : DEBOUNCE_CYCLES  stable samples needed to accept a press or a
//                                release (minimum 2, default 16)
//
// Ports       : clk          in   1  single clock, rising edge
//               rst          in   1  asynchronous, active-high reset
//               row          in   4  active-low row lines, bit 0 = top row
//               column       in   4  active-low column lines, bit 0 = left
//               key_pressed  out  4  code of the last accepted key
//               key_valid    out  1  one-cycle strobe when key_pressed loads
//
// Build option: DETECTOR_MULTIKEY_REJECT_EN
//               defined   - a sample with more than one low row or column bit
//                           is treated as no key
//               undefined - multiple low bits are resolved to the lowest-index
//                           low row and lowest-index low column
//
// Key codes (row, column):
//               row 0 : 1  2  3  A(10)
//               row 1 : 4  5  6  B(11)
//               row 2 : 7  8  9  C(12)
//               row 3 : *(14)  0  #(15)  D(13)
//
// Revision    : 1.0  initial release
//============================================================================
module module_detector #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row,
    input  logic [3:0] column,
    output logic [3:0] key_pressed,
    output logic       key_valid
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    // One spare bit above what DEBOUNCE_CYCLES needs so the counter can
    // saturate without ever aliasing back to a small value.
    localparam int c_CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;

    localparam logic [c_CNT_W-1:0] c_CNT_ZERO = '0;
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_SAT  = '1;

    localparam logic [1:0] c_IDLE     = 2'd0;
    localparam logic [1:0] c_DEBOUNCE = 2'd1;
    localparam logic [1:0] c_PRESSED  = 2'd2;
    localparam logic [1:0] c_RELEASE  = 2'd3;

    // ------------------------------------------------------------------
    // Helper functions
    // ------------------------------------------------------------------
    // Index of the lowest set bit; only meaningful when v is non-zero.
    function automatic logic [1:0] lowest_set(input logic [3:0] v);
        logic [1:0] idx;
        casez (v)
            4'b???1: idx = 2'd0;
            4'b??10: idx = 2'd1;
            4'b?100: idx = 2'd2;
            default: idx = 2'd3;
        endcase
        return idx;
    endfunction

`ifdef DETECTOR_MULTIKEY_REJECT_EN
    // True when exactly one bit of v is set.
    function automatic logic exactly_one(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction
`endif

    // Translate a (row, column) position into the keypad code.
    function automatic logic [3:0] key_code(input logic [1:0] r,
                                            input logic [1:0] c);
        logic [3:0] code;
        case ({r, c})
            4'b00_00: code = 4'd1;
            4'b00_01: code = 4'd2;
            4'b00_10: code = 4'd3;
            4'b00_11: code = 4'd10;
            4'b01_00: code = 4'd4;
            4'b01_01: code = 4'd5;
            4'b01_10: code = 4'd6;
            4'b01_11: code = 4'd11;
            4'b10_00: code = 4'd7;
            4'b10_01: code = 4'd8;
            4'b10_10: code = 4'd9;
            4'b10_11: code = 4'd12;
            4'b11_00: code = 4'd14;
            4'b11_01: code = 4'd0;
            4'b11_10: code = 4'd15;
            default:  code = 4'd13;
        endcase
        return code;
    endfunction

    // ------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------
    logic [3:0]         r_row_s1;
    logic [3:0]         r_row_s2;
    logic [3:0]         r_col_s1;
    logic [3:0]         r_col_s2;

    logic [3:0]         w_row_low;
    logic [3:0]         w_col_low;
    logic               w_cand_valid;
    logic [3:0]         w_cand_code;

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;

    logic [3:0]         r_latch;
    logic [3:0]         w_latch_next;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_next;
    logic [3:0]         r_key_pressed;
    logic [3:0]         w_key_next;
    logic               r_key_valid;
    logic               w_valid_next;

    // ------------------------------------------------------------------
    // Two-flop synchronisers; idle value is "no line pulled low".
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_row_s1 <= 4'b1111;
            r_row_s2 <= 4'b1111;
            r_col_s1 <= 4'b1111;
            r_col_s2 <= 4'b1111;
        end else begin
            r_row_s1 <= row;
            r_row_s2 <= r_row_s1;
            r_col_s1 <= column;
            r_col_s2 <= r_col_s1;
        end
    end

    // ------------------------------------------------------------------
    // Candidate key decode from the synchronised lines
    // ------------------------------------------------------------------
    assign w_row_low = ~r_row_s2;
    assign w_col_low = ~r_col_s2;

`ifdef DETECTOR_MULTIKEY_REJECT_EN
    assign w_cand_valid = exactly_one(w_row_low) && exactly_one(w_col_low);
`else
    // Any low row plus any low column is a key; priority picks the lowest
    // index on each axis when several lines are low.
    assign w_cand_valid = (w_row_low != 4'd0) && (w_col_low != 4'd0);
`endif

    assign w_cand_code = key_code(lowest_set(w_row_low), lowest_set(w_col_low));

    // ------------------------------------------------------------------
    // FSM: state and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= c_IDLE;
            r_latch       <= 4'd0;
            r_cnt         <= c_CNT_ZERO;
            r_key_pressed <= 4'd0;
            r_key_valid   <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_latch       <= w_latch_next;
            r_cnt         <= w_cnt_next;
            r_key_pressed <= w_key_next;
            r_key_valid   <= w_valid_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_cand_valid) begin
                    w_state_next = c_DEBOUNCE;
                end
            end
            c_DEBOUNCE: begin
                if (!w_cand_valid) begin
                    w_state_next = c_IDLE;
                end else if ((w_cand_code == r_latch) && (r_cnt == c_CNT_LAST)) begin
                    w_state_next = c_PRESSED;
                end
            end
            c_PRESSED: begin
                if (!w_cand_valid) begin
                    w_state_next = c_RELEASE;
                end else if (w_cand_code != r_latch) begin
                    // Rolling straight onto another key re-debounces it
                    // without waiting for a release.
                    w_state_next = c_DEBOUNCE;
                end
            end
            c_RELEASE: begin
                if (w_cand_valid) begin
                    w_state_next = c_DEBOUNCE;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_state_next = c_IDLE;
                end
            end
            default: w_state_next = c_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: latch, counter and output register updates
    // ------------------------------------------------------------------
    always_comb begin
        w_latch_next = r_latch;
        w_cnt_next   = r_cnt;
        w_key_next   = r_key_pressed;
        w_valid_next = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (w_cand_valid) begin
                    w_latch_next = w_cand_code;
                    w_cnt_next   = c_CNT_ZERO;
                end
            end
            c_DEBOUNCE: begin
                if (!w_cand_valid) begin
                    w_cnt_next = c_CNT_ZERO;
                end else if (w_cand_code != r_latch) begin
                    w_latch_next = w_cand_code;
                    w_cnt_next   = c_CNT_ZERO;
                end else if (r_cnt == c_CNT_LAST) begin
                    // The entry sample counted as zero, so this is the
                    // DEBOUNCE_CYCLES-th matching sample in this state.
                    w_key_next   = r_latch;
                    w_valid_next = 1'b1;
                end else if (r_cnt != c_CNT_SAT) begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            c_PRESSED: begin
                if (!w_cand_valid) begin
                    // The sample that left PRESSED is the first invalid one.
                    w_cnt_next = c_CNT_ONE;
                end else if (w_cand_code != r_latch) begin
                    w_latch_next = w_cand_code;
                    w_cnt_next   = c_CNT_ZERO;
                end
            end
            c_RELEASE: begin
                if (w_cand_valid) begin
                    w_latch_next = w_cand_code;
                    w_cnt_next   = c_CNT_ZERO;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_cnt_next = c_CNT_ZERO;
                end else if (r_cnt != c_CNT_SAT) begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            default: begin
                w_cnt_next = c_CNT_ZERO;
            end
        endcase
    end

    assign key_pressed = r_key_pressed;
    assign key_valid   = r_key_valid;

endmodule
`default_nettype wire

// File: tb/tb_module_detector.sv
`default_nettype none
//============================================================================
// Module      : tb_module_detector
// Description : Self-checking bench for module_detector. Stimulus pushes the
//               expected key code and acceptance cycle into a scoreboard; a
//               monitor pops and compares on every key_valid strobe.
// Revision    : 1.0  initial release
//============================================================================
module tb_module_detector;

    localparam int c_DC  = 16;
    localparam int c_LAT = 2 + c_DC + 1;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] row;
    logic [3:0] column;
    logic [3:0] key_pressed;
    logic       key_valid;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        logic [3:0] code;
        int         cycle;
    } exp_t;

    exp_t sb[$];

    module_detector #(
        .DEBOUNCE_CYCLES (c_DC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .row         (row),
        .column      (column),
        .key_pressed (key_pressed),
        .key_valid   (key_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every strobe must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (key_valid === 1'b1) begin
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_valid: got key %0d at cycle %0d, required no strobe",
                         key_pressed, cyc);
            end else begin
                e = sb.pop_front();
                if (key_pressed !== e.code || cyc != e.cycle) begin
                    n_fail++;
                    $display("FAIL accept: got key %0d at cycle %0d, required key %0d at cycle %0d",
                             key_pressed, cyc, e.code, e.cycle);
                end
            end
        end
    end

    task automatic drive(input logic [3:0] r, input logic [3:0] c);
        row    = r;
        column = c;
    endtask

    task automatic expect_key(input logic [3:0] code);
        exp_t e;
        e.code  = code;
        e.cycle = cyc + c_LAT;
        sb.push_back(e);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_key(input string name, input logic [3:0] exp);
        n_tests++;
        if (key_pressed !== exp) begin
            n_fail++;
            $display("FAIL %s: key_pressed=%0d, required %0d", name, key_pressed, exp);
        end
    endtask

    // Wait for all outstanding acceptances, bounded.
    task automatic drain(input string name);
        int t = 0;
        while (sb.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: %0d acceptance(s) missing, required 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic check_reset_state(input string name);
        n_tests++;
        if (key_pressed !== 4'd0 || key_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: key_pressed=%0d key_valid=%0b, required 0/0",
                     name, key_pressed, key_valid);
        end
    endtask

    // Direct key-change sequence: row, column, code.
    logic [3:0] seq_row  [7] = '{4'b1110, 4'b1110, 4'b1101, 4'b1101, 4'b1101, 4'b0111, 4'b0111};
    logic [3:0] seq_col  [7] = '{4'b1011, 4'b0111, 4'b1101, 4'b1011, 4'b0111, 4'b1101, 4'b0111};
    logic [3:0] seq_code [7] = '{4'd3,    4'd10,   4'd5,    4'd6,    4'd11,   4'd0,    4'd13};

    initial begin
        rst = 1'b1;
        drive(4'b1110, 4'b1110);
        @(negedge clk);
        check_reset_state("reset_state");
        @(negedge clk);

        // Key 1 held from reset release: one strobe after the full latency.
        rst = 1'b0;
        expect_key(4'd1);
        wait_cycles(100);
        check_key("key1_hold", 4'd1);
        drain("key1");

        // Reset while key 1 is pressed, then key 2 afterwards.
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_reset_state("reset_mid_press");
        end
        rst = 1'b0;
        drive(4'b1110, 4'b1101);
        expect_key(4'd2);
        wait_cycles(40);
        check_key("key2_after_reset", 4'd2);
        drain("key2");

        // Reset mid-debounce of key 7; the held key is re-debounced from scratch.
        drive(4'b1011, 4'b1110);
        wait_cycles(8);
        rst = 1'b1;
        wait_cycles(3);
        check_reset_state("reset_mid_debounce");
        rst = 1'b0;
        expect_key(4'd7);
        wait_cycles(30);
        drain("key7");

        // Reset while 7 is pressed and still held: re-accepted after release.
        rst = 1'b1;
        wait_cycles(2);
        check_reset_state("reset_held_key");
        rst = 1'b0;
        expect_key(4'd7);
        wait_cycles(30);
        check_key("key7_reaccept", 4'd7);
        drain("key7_re");

        // Direct changes between keys with no release in between.
        for (int k = 0; k < 7; k++) begin
            drive(seq_row[k], seq_col[k]);
            expect_key(seq_code[k]);
            wait_cycles(30);
            check_key("direct_change", seq_code[k]);
            drain("direct_change");
        end

        // Release, then bounce key 6 for 40 cycles before it settles.
        drive(4'b1111, 4'b1111);
        wait_cycles(40);
        check_key("release_D_holds", 4'd13);
        for (int p = 0; p < 8; p++) begin
            drive(4'b1101, (p % 2 == 0) ? 4'b1011 : 4'b1111);
            wait_cycles(5);
        end
        check_key("bounce_no_accept", 4'd13);
        drive(4'b1101, 4'b1011);
        expect_key(4'd6);
        wait_cycles(30);
        check_key("bounce_settled", 4'd6);
        drain("bounce");

        // Press 9 then release for 50 cycles: code is retained.
        drive(4'b1011, 4'b1011);
        expect_key(4'd9);
        wait_cycles(25);
        drain("key9");
        drive(4'b1111, 4'b1111);
        wait_cycles(50);
        check_key("release_retains", 4'd9);

        // Two rows low with one column low.
        drive(4'b1100, 4'b1110);
`ifdef DETECTOR_MULTIKEY_REJECT_EN
        wait_cycles(40);
        check_key("multikey_reject", 4'd9);
`else
        expect_key(4'd1);
        wait_cycles(40);
        check_key("multikey_priority", 4'd1);
`endif
        drain("multikey");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/module_detector.md
MODULE_DETECTOR -- requirements
Module: module_detector

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16, SHALL set the stable-sample count (min 2) required to accept a press or release.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-004 row  input  4  SHALL be the active-low keypad row lines, bit 0 = top row; asynchronous to clk.
REQ-005 column  input  4  SHALL be the active-low keypad column lines, bit 0 = left column; asynchronous to clk.
REQ-006 key_pressed  output  4  SHALL be the registered code of the last accepted key.
REQ-007 key_valid  output  1  SHALL be a one-cycle strobe that pulses when key_pressed is loaded; it MAY be left unconnected.

Function
REQ-008 row and column SHALL each pass through a 2-flop synchronizer (reset value 4'b1111) before any decoding.
REQ-009 A candidate key SHALL be valid only when exactly one synchronized row bit and exactly one synchronized column bit are 0.
REQ-010 Key map by (row,col): r0: 1,2,3,A=10; r1: 4,5,6,B=11; r2: 7,8,9,C=12; r3: *=14, 0=0, #=15, D=13.
REQ-011 The FSM SHALL have four states: IDLE, DEBOUNCE, PRESSED, RELEASE.
REQ-012 IDLE SHALL latch any valid candidate, clear the counter and enter DEBOUNCE.
REQ-013 DEBOUNCE SHALL increment the counter each cycle the candidate equals the latched code.
REQ-014 DEBOUNCE SHALL return to IDLE if the candidate becomes invalid.
REQ-015 DEBOUNCE SHALL relatch and restart the count if the candidate changes to another valid code.
REQ-016 DEBOUNCE SHALL enter PRESSED, load key_pressed and pulse key_valid on the cycle the counter reaches DEBOUNCE_CYCLES-1.
REQ-017 PRESSED SHALL hold key_pressed unchanged while the same key remains valid.
REQ-018 PRESSED SHALL go to DEBOUNCE with a new latched code when a different valid key appears, with no intermediate release required.
REQ-019 PRESSED SHALL go to RELEASE when the candidate is invalid.
REQ-020 RELEASE SHALL return to IDLE after DEBOUNCE_CYCLES consecutive invalid samples.
REQ-021 RELEASE SHALL go to DEBOUNCE if any valid candidate appears before that count completes.
REQ-022 key_pressed SHALL keep the last accepted code after release; it changes only on acceptance or reset.
REQ-023 Latency from a stable input change to key_pressed update SHALL be exactly 2 (sync) + DEBOUNCE_CYCLES + 1 cycles, i.e. 19 cycles at the default.
REQ-024 The debounce counter SHALL be $clog2(DEBOUNCE_CYCLES)+1 bits wide and SHALL saturate, never wrap.

Reset
REQ-025 While rst=1, the FSM SHALL be in IDLE, key_pressed=4'd0, key_valid=0, the counter=0 and the synchronizers=4'b1111.
REQ-026 Reset asserted mid-debounce or mid-press SHALL abort immediately; a key still held after release of reset SHALL be re-debounced from IDLE and re-accepted.

Configuration
REQ-027 With DETECTOR_MULTIKEY_REJECT_EN defined, any sample with more than one low row or column bit SHALL be treated as invalid, per REQ-009.
REQ-028 Without DETECTOR_MULTIKEY_REJECT_EN, multiple low bits SHALL be resolved by priority to the lowest-index low row and the lowest-index low column, and the result SHALL be treated as valid.

Verification
REQ-029 Scenario: reset 20 ns, then row=1110 column=1110 held for 100 cycles -> key_pressed=1, exactly one key_valid pulse, 19 cycles after release of reset.
REQ-030 Scenario: hold key 1, assert rst for 10 cycles, release rst, then drive row=1110 column=1101 -> key_pressed=0 during reset, then 2.
REQ-031 Scenario: direct key changes without release, in order 3 (1110/1011), A (1110/0111), 5 (1101/1101), 6, B, 0 (0111/1101), D (0111/0111) -> each code is accepted within 100 cycles.
REQ-032 Scenario: bounce of key 6 with the column toggling every 5 cycles for 40 cycles, then stable -> no key_valid during the bounce, one key_valid after the stable period.
REQ-033 Scenario: press 9, release to 1111/1111 for 50 cycles -> key_pressed stays 9 and the FSM returns to IDLE.
REQ-034 Scenario: row=1100 column=1110 -> with DETECTOR_MULTIKEY_REJECT_EN defined, no acceptance; without it, key_pressed=1.
